code_lock_core: RTL

Parametrised digital-lock engine: it replaces the fixed 4-button lock behind the debouncer and edge-detector stage.

- Accepts one-cycle button pulses from `NUM_BTN` buttons and matches a `CODE_LEN`-digit sequence against a stored code.
- The stored code is reprogrammable while unlocked.
- Locks out entry for a fixed number of cycles after `MAX_FAIL` consecutive wrong codes.
- Outputs drive the LED/seven-segment status logic.

---
 rtl/code_lock_pkg.sv | 28 ++
 rtl/code_lock_core_if.sv | 30 +++
 rtl/code_lock_core_down_timer.sv | 31 +++
 rtl/code_lock_core.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/code_lock_pkg.sv
// code_lock_pkg: shared state encoding and width helpers for the code lock engine.
// Revision 1.0
`default_nettype none

package code_lock_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_LOCKED  = 2'd0;
  localparam state_t ST_OPEN    = 2'd1;
  localparam state_t ST_PROG    = 2'd2;
  localparam state_t ST_LOCKOUT = 2'd3;

  function automatic int btn_w(input int num_btn);
    return (num_btn > 1) ? $clog2(num_btn) : 1;
  endfunction

  function automatic int cnt_w(input int code_len);
    return $clog2(code_len + 1);
  endfunction

  function automatic int fail_w(input int max_fail);
    return $clog2(max_fail + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/code_lock_core_if.sv
// code_lock_core_if: button/programming inputs and status outputs of the code lock.
// Revision 1.0
`default_nettype none

interface code_lock_core_if #(
  parameter int NUM_BTN  = 4,
  parameter int CODE_LEN = 4,
  parameter int MAX_FAIL = 3
);
  logic [NUM_BTN-1:0]                            btn_pulse;
  logic                                          prog_req;
  logic                                          unlocked;
  logic                                          lockout;
  logic                                          prog_mode;
  logic [code_lock_pkg::cnt_w(CODE_LEN)-1:0]     digit_cnt;
  logic [code_lock_pkg::fail_w(MAX_FAIL)-1:0]    fail_cnt;
  logic                                          err_pulse;

  modport master (
    output btn_pulse, prog_req,
    input  unlocked, lockout, prog_mode, digit_cnt, fail_cnt, err_pulse
  );

  modport slave (
    input  btn_pulse, prog_req,
    output unlocked, lockout, prog_mode, digit_cnt, fail_cnt, err_pulse
  );
endinterface

`default_nettype wire

// File: rtl/code_lock_core_down_timer.sv
// down_timer: loadable down-counter that holds at zero and flags it.
// Revision 1.0
`default_nettype none

module down_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                  cnt_d = load_val;
    else if (en && cnt_q != '0) cnt_d = cnt_q - WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

`default_nettype wire

// File: rtl/code_lock_core.sv
// code_lock_core: code-entry lock with lockout and reprogramming; optional idle
// relock when CODE_LOCK_RELOCK_EN is defined. Revision 1.0
`default_nettype none

module code_lock_core #(
  parameter int NUM_BTN  = 4,
  parameter int CODE_LEN = 4,
  parameter logic [CODE_LEN*code_lock_pkg::btn_w(NUM_BTN)-1:0] DEFAULT_CODE = '0,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 1000,
  parameter int RELOCK_CYC  = 5000
) (
  input  logic           clk,
  input  logic           rst_n,
  code_lock_core_if.slave bus
);
  import code_lock_pkg::*;

  localparam int BTN_W  = btn_w(NUM_BTN);
  localparam int CNT_W  = cnt_w(CODE_LEN);
  localparam int FAIL_W = fail_w(MAX_FAIL);
  localparam int CODE_W = CODE_LEN * BTN_W;
  localparam int LK_W   = $clog2(LOCKOUT_CYC + 1);

  // Returns {more-than-one-bit-set, index}; the index is only meaningful for one-hot input.
  function automatic logic [BTN_W:0] encode_btn(input logic [NUM_BTN-1:0] v);
    logic [BTN_W-1:0] idx;
    logic             seen;
    logic             multi;
    idx   = '0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (v[i]) begin
        multi = multi | seen;
        seen  = 1'b1;
        idx   = idx | BTN_W'(i);
      end
    end
    return {multi, idx};
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   digit_q, digit_d;
  logic [FAIL_W-1:0]  fail_q, fail_d;
  logic               miss_q, miss_d;
  logic               err_q, err_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [CODE_W-1:0]  stage_q, stage_d;

  logic               press, valid, last, miss_now;
  logic [BTN_W:0]     enc;
  logic [BTN_W-1:0]   digit;
  logic               lk_load, lk_zero, relock_zero;

  assign enc   = encode_btn(bus.btn_pulse);
  assign digit = enc[BTN_W-1:0];
  assign press = |bus.btn_pulse;
  assign valid = press && !enc[BTN_W];
  assign last  = (digit_q == CNT_W'(CODE_LEN - 1));
  assign miss_now = miss_q || !valid || (digit != code_q[int'(digit_q)*BTN_W +: BTN_W]);

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    fail_d  = fail_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    code_d  = code_q;
    stage_d = stage_q;
    lk_load = 1'b0;
    case (state_q)
      ST_LOCKED: if (press) begin
        if (last) begin
          digit_d = '0;
          miss_d  = 1'b0;
          if (!miss_now) begin
            state_d = ST_OPEN;
            fail_d  = '0;
          end else begin
            err_d  = 1'b1;
            fail_d = fail_q + FAIL_W'(1);
            if (fail_q == FAIL_W'(MAX_FAIL - 1)) begin
              state_d = ST_LOCKOUT;
              lk_load = 1'b1;
            end
          end
        end else begin
          digit_d = digit_q + CNT_W'(1);
          miss_d  = miss_now;
        end
      end
      ST_LOCKOUT: begin
        digit_d = '0;
        if (lk_zero) begin
          state_d = ST_LOCKED;
          fail_d  = '0;
        end
      end
      ST_OPEN: begin
        digit_d = '0;
        if (bus.prog_req)            state_d = ST_PROG;
        else if (press || relock_zero) state_d = ST_LOCKED;
      end
      ST_PROG: if (press) begin
        if (!valid) begin
          err_d   = 1'b1;
          digit_d = '0;
          state_d = ST_OPEN;
        end else begin
          stage_d[int'(digit_q)*BTN_W +: BTN_W] = digit;
          if (last) begin
            code_d  = stage_d;
            digit_d = '0;
            state_d = ST_OPEN;
          end else begin
            digit_d = digit_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_LOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOCKED;
      digit_q <= '0;
      fail_q  <= '0;
      miss_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= DEFAULT_CODE;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      fail_q  <= fail_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      code_q  <= code_d;
      stage_q <= stage_d;
    end
  end

  down_timer #(.WIDTH(LK_W)) u_lockout_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lk_load),
    .load_val (LK_W'(LOCKOUT_CYC - 1)),
    .en       (state_q == ST_LOCKOUT),
    .zero     (lk_zero)
  );

`ifdef CODE_LOCK_RELOCK_EN
  localparam int RL_W = $clog2(RELOCK_CYC + 1);
  logic relock_load;
  // Reload on every entry to OPEN (including the return from PROG) and on any activity in OPEN.
  assign relock_load = ((state_d == ST_OPEN) && (state_q != ST_OPEN)) ||
                       ((state_q == ST_OPEN) && (press || bus.prog_req));

  down_timer #(.WIDTH(RL_W)) u_relock_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (relock_load),
    .load_val (RL_W'(RELOCK_CYC - 1)),
    .en       (state_q == ST_OPEN),
    .zero     (relock_zero)
  );
`else
  logic relock_unused;
  assign relock_unused = (RELOCK_CYC > 0);
  assign relock_zero   = 1'b0;
`endif

  assign bus.unlocked  = (state_q == ST_OPEN) || (state_q == ST_PROG);
  assign bus.lockout   = (state_q == ST_LOCKOUT);
  assign bus.prog_mode = (state_q == ST_PROG);
  assign bus.digit_cnt = digit_q;
  assign bus.fail_cnt  = fail_q;
  assign bus.err_pulse = err_q;
endmodule

`default_nettype wire
